// File: rtl/prbs_os_rec_par.sv
// PRBS11 (x^11+x^9+1) ordered-set checker, DATA_W bits per beat, data_in[0] earliest.
// Flags each OS as clean or bad, tracks lock over consecutive clean OS and counts bad OS.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | seed loaded from lane_sel, beat/flag/lock cleared, no checking
//   CHECK  | one beat consumed per data_valid cycle, OS result at last beat
module prbs_os_rec_par #(
    parameter int          DATA_W         = 1,
    parameter int          OS_LEN         = 448,
    parameter int          SKIP_BITS      = 28,
    parameter logic [10:0] SEED0          = 11'h7FF,
    parameter logic [10:0] SEED1          = 11'h770,
    parameter bit          RELOAD_EACH_OS = 1'b1,
    parameter int          LOCK_CNT       = 2,
    parameter int          ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 lane_sel,
    input  logic                 data_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 clr_err,
    output logic                 os_ok,
    output logic                 os_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                BEATS     = OS_LEN / DATA_W;
    localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        LOCK_MAX  = 4'(LOCK_CNT);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CHECK = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [10:0]          lfsr_q, lfsr_d;
    logic [10:0]          seed_q, seed_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 mis_q, mis_d;
    logic [3:0]           run_q, run_d;
    logic                 locked_q, locked_d;
    logic                 os_ok_q, os_ok_d;
    logic                 os_err_q, os_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [10:0]          lfsr_adv;
    logic                 beat_mis;

    // Unrolled DATA_W single-bit shifts; expected bit i is the MSB before shift i.
    always_comb begin
        lfsr_adv = lfsr_q;
        beat_mis = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if ((data_in[i] != lfsr_adv[10]) &&
                ((int'(beat_q) * DATA_W + i) >= SKIP_BITS)) begin
                beat_mis = 1'b1;
            end
            lfsr_adv = {lfsr_adv[9:0], lfsr_adv[10] ^ lfsr_adv[8]};
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        seed_d    = seed_q;
        beat_d    = beat_q;
        mis_d     = mis_q;
        run_d     = run_q;
        locked_d  = locked_q;
        os_ok_d   = 1'b0;
        os_err_d  = 1'b0;
        err_cnt_d = err_cnt_q;

        // Counts the registered os_err pulse, so a clear in the pulse cycle wins.
        if (os_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        if (clr_err) begin
            err_cnt_d = '0;
        end

        if (!enable || (state_q == ST_IDLE)) begin
            state_d  = enable ? ST_CHECK : ST_IDLE;
            seed_d   = lane_sel ? SEED1 : SEED0;
            lfsr_d   = seed_d;
            beat_d   = '0;
            mis_d    = 1'b0;
            run_d    = '0;
            locked_d = 1'b0;
        end else if (data_valid) begin
            if (beat_q == LAST_BEAT) begin
                beat_d = '0;
                mis_d  = 1'b0;
                lfsr_d = RELOAD_EACH_OS ? seed_q : lfsr_adv;
                if (mis_q || beat_mis) begin
                    os_err_d = 1'b1;
                    run_d    = '0;
                    locked_d = 1'b0;
                end else begin
                    os_ok_d = 1'b1;
                    if (run_q < LOCK_MAX) begin
                        run_d = run_q + 4'd1;
                    end
                    locked_d = (run_d == LOCK_MAX);
                end
            end else begin
                beat_d = beat_q + BEAT_W'(1);
                mis_d  = mis_q | beat_mis;
                lfsr_d = lfsr_adv;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= SEED0;
            seed_q    <= SEED0;
            beat_q    <= '0;
            mis_q     <= 1'b0;
            run_q     <= '0;
            locked_q  <= 1'b0;
            os_ok_q   <= 1'b0;
            os_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            seed_q    <= seed_d;
            beat_q    <= beat_d;
            mis_q     <= mis_d;
            run_q     <= run_d;
            locked_q  <= locked_d;
            os_ok_q   <= os_ok_d;
            os_err_q  <= os_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign os_ok   = os_ok_q;
    assign os_err  = os_err_q;
    assign locked  = locked_q;
    assign err_cnt = err_cnt_q;

endmodule
